// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply (STEP bits per cycle) and optional restoring
// divide with HI/LO result registers. Divider is built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multE,
  input  logic             divE,
  input  logic             is_signedE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     ub_q, ub_d;
  logic                 neg_q, neg_d, rneg_q, rneg_d, div_q, div_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 dbz_q, dbz_d;
  logic                 div_req, req;
  logic [WIDTH+STEP-1:0] pp, acc;
  logic [2*WIDTH-1:0]   mul_nxt, step_nxt, res;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] s;
    s = v;
    return (sgn && s[WIDTH-1]) ? -s : s;
  endfunction

  function automatic logic [WIDTH-1:0] fixw(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix2(input logic [2*WIDTH-1:0] v, input logic neg);
    logic signed [2*WIDTH-1:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  // Multiply slice: work_q holds {partial high, unretired multiplier bits}
  assign pp      = {{STEP{1'b0}}, ub_q} * {{WIDTH{1'b0}}, work_q[STEP-1:0]};
  assign acc     = {{STEP{1'b0}}, work_q[2*WIDTH-1:WIDTH]} + pp;
  assign mul_nxt = {acc, work_q[WIDTH-1:STEP]};

`ifdef MULDIV_DIV_EN
  // Restoring divide bit: work_q holds {remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]     shifted, trial;
  logic [2*WIDTH-1:0] div_nxt;
  assign shifted  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, ub_q};
  assign div_nxt  = trial[WIDTH] ? {shifted[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0],   work_q[WIDTH-2:0], 1'b1};
  assign step_nxt = div_q ? div_nxt : mul_nxt;
  assign res      = div_q ? {fixw(div_nxt[2*WIDTH-1:WIDTH], rneg_q), fixw(div_nxt[WIDTH-1:0], neg_q)}
                          : fix2(mul_nxt, neg_q);
  assign div_req     = divE & ~multE;
  assign div_by_zero = dbz_q;
`else
  logic unused_div;
  assign unused_div  = ^{divE, rneg_q, dbz_q};
  assign step_nxt    = mul_nxt;
  assign res         = fix2(mul_nxt, neg_q);
  assign div_req     = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  assign req = multE | div_req;
  assign hi  = hi_q;
  assign lo  = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    ub_d    = ub_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !flushE) begin
          stall  = 1'b1;
          div_d  = div_req;
          neg_d  = is_signedE & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = is_signedE & a[WIDTH-1];
          state_d = RUN;
          if (div_req) begin
            ub_d   = mag(b, is_signedE);
            work_d = {{WIDTH{1'b0}}, mag(a, is_signedE)};
            cnt_d  = CNT_W'(WIDTH);
            if (b == '0) begin
              lo_d    = '1;
              hi_d    = a;
              dbz_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            ub_d   = mag(a, is_signedE);
            work_d = {{WIDTH{1'b0}}, mag(b, is_signedE)};
            cnt_d  = CNT_W'(WIDTH / STEP);
          end
        end
      end
      RUN: begin
        stall = 1'b1;
        if (flushE) begin
          state_d = IDLE;
        end else begin
          work_d = step_nxt;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            hi_d    = res[2*WIDTH-1:WIDTH];
            lo_d    = res[WIDTH-1:0];
            dbz_d   = div_q;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      div_q   <= div_d;
    end
  end

  always_ff @(posedge clk) begin
    work_q <= work_d;
    ub_q   <= ub_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: STEP=1 and STEP=4 instances checked each cycle
// against an arithmetic model of stall timing and HI/LO/div_by_zero contents.
module tb_muldiv_unit;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        multE1 = 1'b0, multE4 = 1'b0, divE = 1'b0;
  logic        is_signedE = 1'b0, flushE = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        stall1, stall4, dbz1, dbz4;
  logic [31:0] hi1, lo1, hi4, lo4;

  bit          sel = 1'b0;
  bit          chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_dbz = 1'b0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .multE(multE1), .divE(divE), .is_signedE(is_signedE),
    .flushE(flushE), .a(a), .b(b), .stall(stall1), .hi(hi1), .lo(lo1), .div_by_zero(dbz1)
  );

  muldiv_unit #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .multE(multE4), .divE(1'b0), .is_signedE(is_signedE),
    .flushE(flushE), .a(a), .b(b), .stall(stall4), .hi(hi4), .lo(lo4), .div_by_zero(dbz4)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_mul(input logic [31:0] x, input logic [31:0] y, input bit sgn);
    logic [63:0] px, py;
    px = sgn ? {{32{x[31]}}, x} : {32'h0, x};
    py = sgn ? {{32{y[31]}}, y} : {32'h0, y};
    return px * py;
  endfunction

  function automatic logic [63:0] model_div(input logic [31:0] x, input logic [31:0] y, input bit sgn);
    int sx, sy;
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sx = x;
      sy = y;
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {x % y, x / y};
  endfunction

  // Per-cycle comparison against the model's expected outputs
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {63'h0, sel ? stall4 : stall1}, {63'h0, exp_stall});
      check("hi", {32'h0, sel ? hi4 : hi1}, {32'h0, exp_hi});
      check("lo", {32'h0, sel ? lo4 : lo1}, {32'h0, exp_lo});
      check("div_by_zero", {63'h0, sel ? dbz4 : dbz1}, {63'h0, exp_dbz});
    end
  end

  task automatic do_op(input bit is_div, input bit both, input bit sgn,
                       input logic [31:0] aa, input logic [31:0] bb);
    logic [63:0] r;
    bit acc, dz;
    int lat;
    acc = !is_div || DIV_EN;
    dz  = is_div && (bb == 32'h0);
    r   = is_div ? model_div(aa, bb, sgn) : model_mul(aa, bb, sgn);
    lat = !acc ? 0 : (is_div ? (dz ? 0 : 32) : (sel ? 8 : 32));
    @(posedge clk); #1;
    a = aa; b = bb; is_signedE = sgn;
    if (is_div) divE = 1'b1;
    else begin
      if (sel) multE4 = 1'b1; else multE1 = 1'b1;
      divE = both;
    end
    exp_stall = acc;
    for (int k = 0; k < lat; k++) begin
      @(posedge clk); #1;
      exp_stall = 1'b1;
    end
    @(posedge clk); #1;
    exp_stall = 1'b0;
    if (acc) begin
      {exp_hi, exp_lo} = r;
      exp_dbz = dz;
    end
    @(posedge clk); #1;
    multE1 = 1'b0; multE4 = 1'b0; divE = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [63:0] v);
    check(nm, sel ? {hi4, lo4} : {hi1, lo1}, v);
  endtask

  task automatic flush_op(input logic [31:0] aa, input logic [31:0] bb);
    @(posedge clk); #1;
    a = aa; b = bb; is_signedE = 1'b1; multE1 = 1'b1;
    exp_stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        flushE = 1'b1;
        multE1 = 1'b0;
      end
    end
    @(posedge clk); #1;
    flushE = 1'b0;
    exp_stall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_op(input logic [31:0] aa, input logic [31:0] bb);
    @(posedge clk); #1;
    a = aa; b = bb; is_signedE = 1'b0; multE1 = 1'b1;
    exp_stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 5) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    multE1 = 1'b0;
    exp_stall = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(0, 0, 1, 32'd87359729, 32'd23422);
    lit("mul_signed_small", 64'd2046139572638);
    do_op(0, 0, 1, 32'h8000_0000, 32'h8000_0000);
    lit("mul_signed_min", 64'h4000_0000_0000_0000);
    do_op(0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lit("mul_unsigned_max", 64'hFFFF_FFFE_0000_0001);
    do_op(0, 0, 1, 32'hFFFF_FFF9, 32'd6);

    do_op(1, 0, 1, 32'hFFFF_FFF9, 32'd2);
    if (DIV_EN) lit("div_neg7_by_2", {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    if (DIV_EN) lit("div_min_by_m1", {32'h0, 32'h8000_0000});
    do_op(1, 0, 0, 32'hFFFF_FFF0, 32'd7);
    do_op(1, 0, 1, 32'd100, 32'hFFFF_FFF9);
    do_op(1, 0, 1, 32'd123, 32'd0);
    if (DIV_EN) lit("div_by_zero", {32'd123, 32'hFFFF_FFFF});
    do_op(0, 1, 1, 32'd3, 32'hFFFF_FFFB);
    lit("mul_priority", 64'hFFFF_FFFF_FFFF_FFF1);

    flush_op(32'd1000, 32'd2000);
    reset_op(32'd55, 32'd66);
    do_op(0, 0, 0, 32'd12345, 32'd678);

    @(posedge clk); #1;
    sel = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    do_op(0, 0, 1, 32'hFFFF_FFB3, 32'd999);
    lit("step4_mul_signed", 64'hFFFF_FFFF_FFFE_D385);
    do_op(0, 0, 0, 32'hDEAD_BEEF, 32'h1234_5679);
    do_op(0, 0, 1, 32'h8000_0000, 32'h7FFF_FFFF);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
